// File: rtl/term_turnaround_matrix.sv
// Edge-tile turnaround matrix: routes END wires back as BEG wires per group, using a
// serially loaded shadow/active config. Macro TERM_TURNAROUND_REG_EN builds per-group output flops.
module term_turnaround_matrix #(
    parameter int GRP_W = 8,
    parameter int N_GRP = 4
) (
    input  logic                   UserCLK,
    input  logic                   rst_n,
    input  logic [N_GRP*GRP_W-1:0] in_end,
    output logic [N_GRP*GRP_W-1:0] out_beg,
    input  logic                   cfg_sdi,
    input  logic                   cfg_shift,
    input  logic                   cfg_commit,
    output logic                   cfg_sdo,
    output logic                   cfg_ready,
    output logic                   cfg_err
);
    localparam int CFG_BITS = 3 * N_GRP;
    localparam int CNT_W    = $clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                commit_ok;
    logic [N_GRP-1:0]    reg_en;

    assign cfg_ready = (cnt_q == CNT_FULL);
    assign cfg_sdo   = shadow_q[CFG_BITS-1];
    assign cfg_err   = err_q;
    assign commit_ok = cfg_commit && !cfg_shift && cfg_ready;

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        // A shift still executes even when it causes the paired commit to be rejected.
        if (cfg_shift) begin
            shadow_d = {shadow_q[CFG_BITS-2:0], cfg_sdi};
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (commit_ok) begin
            active_d = shadow_q;
            cnt_d    = '0;
            err_d    = 1'b0;
        end else if (cfg_commit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge UserCLK or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    for (genvar gi = 0; gi < N_GRP; gi++) begin : g_grp
        logic [GRP_W-1:0] grp_in;
        logic [GRP_W-1:0] routed;
        logic [1:0]       mode;

        assign grp_in     = in_end[gi*GRP_W +: GRP_W];
        assign mode       = active_q[3*gi +: 2];
        assign reg_en[gi] = active_q[3*gi+2];

        always_comb begin
            routed = '0;
            unique case (mode)
                2'b00: begin
                    for (int i = 0; i < GRP_W; i++) begin
                        routed[i] = grp_in[GRP_W-1-i];
                    end
                end
                2'b01:   routed = grp_in;
                2'b10:   routed = '0;
                default: routed = '1;
            endcase
        end

`ifdef TERM_TURNAROUND_REG_EN
        logic [GRP_W-1:0] stage_q;

        // The stage always tracks the routed value so enabling it never exposes stale data.
        always_ff @(posedge UserCLK or negedge rst_n) begin
            if (!rst_n) begin
                stage_q <= '0;
            end else begin
                stage_q <= routed;
            end
        end

        assign out_beg[gi*GRP_W +: GRP_W] = reg_en[gi] ? stage_q : routed;
`else
        assign out_beg[gi*GRP_W +: GRP_W] = routed;
`endif
    end

`ifndef TERM_TURNAROUND_REG_EN
    // reg_en bits stay in the chain for bitstream compatibility but have no effect here.
    logic unused_reg_en;
    assign unused_reg_en = ^reg_en;
`endif

endmodule

// File: tb/tb_term_turnaround_matrix.sv
// Randomised + directed bench for term_turnaround_matrix against a bit-level behavioural model.
module tb_term_turnaround_matrix;
`ifdef TERM_TURNAROUND_REG_EN
    localparam bit REG_BUILT = 1'b1;
`else
    localparam bit REG_BUILT = 1'b0;
`endif

    logic        UserCLK;
    logic        rst_n;
    logic [31:0] in_end;
    logic [31:0] out_beg;
    logic        cfg_sdi, cfg_shift, cfg_commit;
    logic        cfg_sdo, cfg_ready, cfg_err;

    term_turnaround_matrix #(.GRP_W(8), .N_GRP(4)) dut (
        .UserCLK    (UserCLK),
        .rst_n      (rst_n),
        .in_end     (in_end),
        .out_beg    (out_beg),
        .cfg_sdi    (cfg_sdi),
        .cfg_shift  (cfg_shift),
        .cfg_commit (cfg_commit),
        .cfg_sdo    (cfg_sdo),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err)
    );

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [11:0] m_shadow;
    logic [11:0] m_active;
    int          m_cnt;
    bit          m_err;
    logic [7:0]  m_stage [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] route(input logic [7:0] x, input logic [1:0] m);
        logic [7:0] r;
        case (m)
            2'd0:    r = {<<{x}};
            2'd1:    r = x;
            2'd2:    r = 8'h00;
            default: r = 8'hFF;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] exp_out(input logic [31:0] din);
        logic [31:0] e;
        for (int g = 0; g < 4; g++) begin
            if (REG_BUILT && m_active[3*g+2])
                e[g*8 +: 8] = m_stage[g];
            else
                e[g*8 +: 8] = route(din[g*8 +: 8], m_active[3*g +: 2]);
        end
        return e;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".out"},   out_beg, exp_out(in_end));
        chk({tag, ".ready"}, {31'b0, cfg_ready}, {31'b0, (m_cnt == 12)});
        chk({tag, ".sdo"},   {31'b0, cfg_sdo}, {31'b0, m_shadow[11]});
        chk({tag, ".err"},   {31'b0, cfg_err}, {31'b0, m_err});
    endtask

    task automatic model_reset();
        m_shadow = '0;
        m_active = '0;
        m_cnt    = 0;
        m_err    = 1'b0;
        for (int g = 0; g < 4; g++) m_stage[g] = 8'h00;
    endtask

    // Apply inputs away from the active edge and check the pre-edge outputs.
    task automatic drive(input string tag, input logic sdi, input logic sh, input logic cm,
                         input logic [31:0] din);
        @(negedge UserCLK);
        cfg_sdi = sdi; cfg_shift = sh; cfg_commit = cm; in_end = din;
        #1;
        check_all(tag);
    endtask

    task automatic tick();
        bit accept;
        @(posedge UserCLK);
        for (int g = 0; g < 4; g++) m_stage[g] = route(in_end[g*8 +: 8], m_active[3*g +: 2]);
        accept = cfg_commit && !cfg_shift && (m_cnt == 12);
        if (accept) begin
            m_active = m_shadow;
            m_cnt    = 0;
            m_err    = 1'b0;
        end else if (cfg_commit) begin
            m_err = 1'b1;
        end
        if (cfg_shift) begin
            m_shadow = {m_shadow[10:0], cfg_sdi};
            if (m_cnt < 12) m_cnt++;
        end
        $display("cyc sh=%0b sdi=%0b cm=%0b in=%h out=%h rdy=%0b err=%0b",
                 cfg_shift, cfg_sdi, cfg_commit, in_end, out_beg, cfg_ready, cfg_err);
    endtask

    task automatic cycle(input string tag, input logic sdi, input logic sh, input logic cm,
                         input logic [31:0] din);
        drive(tag, sdi, sh, cm, din);
        tick();
    endtask

    task automatic load(input logic [11:0] v, input int nbits);
        for (int k = 0; k < nbits; k++) cycle("shift", v[11-k], 1'b1, 1'b0, $urandom);
    endtask

    task automatic do_reset(input logic [31:0] din);
        @(negedge UserCLK);
        rst_n = 1'b0;
        in_end = din;
        cfg_shift = 1'b0; cfg_commit = 1'b0; cfg_sdi = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        chk("reset.legacy", out_beg, {in_end[24], in_end[25], in_end[26], in_end[27],
                                      in_end[28], in_end[29], in_end[30], in_end[31],
                                      in_end[16], in_end[17], in_end[18], in_end[19],
                                      in_end[20], in_end[21], in_end[22], in_end[23],
                                      in_end[8],  in_end[9],  in_end[10], in_end[11],
                                      in_end[12], in_end[13], in_end[14], in_end[15],
                                      in_end[0],  in_end[1],  in_end[2],  in_end[3],
                                      in_end[4],  in_end[5],  in_end[6],  in_end[7]});
        @(negedge UserCLK);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_end = '0;
        cfg_sdi = 1'b0; cfg_shift = 1'b0; cfg_commit = 1'b0;
        model_reset();

        // Legacy reversal out of reset
        do_reset(32'h0000_00A5);
        drive("legacy_a5", 1'b0, 1'b0, 1'b0, 32'h0000_00A5);
        chk("legacy_a5.k", out_beg, 32'h0000_00A5);
        tick();
        drive("legacy_01", 1'b0, 1'b0, 1'b0, 32'h0000_0001);
        chk("legacy_01.k", out_beg, 32'h0000_0080);
        tick();

        // Group0 straight
        load(12'h001, 12);
        drive("rdy12", 1'b0, 1'b0, 1'b1, 32'h0);
        chk("rdy12.k", {31'b0, cfg_ready}, 32'd1);
        tick();
        drive("straight", 1'b0, 1'b0, 1'b0, 32'h0000_0001);
        chk("straight.k", out_beg, 32'h0000_0001);
        chk("straight.err", {31'b0, cfg_err}, 32'd0);
        tick();

        // Early commit rejected, then completed
        load(12'h098, 11);
        cycle("early_cm", 1'b0, 1'b0, 1'b1, 32'h0000_0001);
        drive("early_after", 1'b0, 1'b0, 1'b0, 32'h0000_0001);
        chk("early.err", {31'b0, cfg_err}, 32'd1);
        chk("early.route", out_beg, 32'h0000_0001);
        tick();
        cycle("last_bit", 1'b0, 1'b1, 1'b0, $urandom);
        cycle("commit2", 1'b0, 1'b0, 1'b1, $urandom);
        for (int k = 0; k < 3; k++) begin
            drive("ties", 1'b0, 1'b0, 1'b0, $urandom);
            chk("ties.g1", {24'b0, out_beg[15:8]}, 32'h0000_00FF);
            chk("ties.g2", {24'b0, out_beg[23:16]}, 32'h0000_0000);
            chk("ties.err", {31'b0, cfg_err}, 32'd0);
            tick();
        end

        // Simultaneous shift + commit is rejected but the shift happens
        load(12'h800, 11);
        cycle("sh_cm", 1'b0, 1'b1, 1'b1, 32'h0);
        drive("sh_cm_after", 1'b0, 1'b0, 1'b0, 32'h0);
        chk("sh_cm.err", {31'b0, cfg_err}, 32'd1);
        chk("sh_cm.rdy", {31'b0, cfg_ready}, 32'd1);
        tick();

        // Group3 registered reversal
        load(12'h800, 12);
        cycle("commit3", 1'b0, 1'b0, 1'b1, 32'h0);
        cycle("g3_zero", 1'b0, 1'b0, 1'b0, 32'h0);
        drive("g3_step", 1'b0, 1'b0, 1'b0, 32'h0100_0000);
        chk("g3_step.k", {24'b0, out_beg[31:24]}, REG_BUILT ? 32'h0 : 32'h80);
        tick();
        drive("g3_next", 1'b0, 1'b0, 1'b0, 32'h0100_0000);
        chk("g3_next.k", {24'b0, out_beg[31:24]}, 32'h80);
        tick();

        // Reset mid-shift with a sticky error pending
        cycle("rej", 1'b0, 1'b0, 1'b1, $urandom);
        load(12'hFFF, 5);
        do_reset(32'h0100_00A5);
        drive("post_rst", 1'b0, 1'b0, 1'b0, 32'h0000_0001);
        chk("post_rst.k", out_beg, 32'h0000_0080);
        chk("post_rst.rdy", {31'b0, cfg_ready}, 32'd0);
        chk("post_rst.sdo", {31'b0, cfg_sdo}, 32'd0);
        tick();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset($urandom);
            end else begin
                cycle("rand", 1'($urandom), ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 7) == 0), $urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
